// File: rtl/dct_zigzag_buf.sv
// rtl/dct_zigzag_buf.sv - DCT block reorder buffer: row-major capture, zigzag replay
// Ping-pong 64-entry banks; writer never stalls the DCT, reader streams with a 2-entry skid.
module dct_zigzag_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [5:0]            out_index,
  output logic                  overflow
);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_t;
  typedef enum logic {W_FILL, W_STALL} wstate_t;
  typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [DATA_WIDTH-1:0] mem_q [2][64];

  bank_t   bank_q [2];
  bank_t   bank_d [2];
  wstate_t ws_q, ws_d;
  rstate_t rs_q, rs_d;
  logic    wb_q, wb_d, rb_q, rb_d;
  logic [5:0] wc_q, wc_d, rc_q, rc_d;
  logic    ovf_q, ovf_d;

  logic                  rd_valid_q, rd_valid_d;
  logic [5:0]            rd_idx_q, rd_idx_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic [DATA_WIDTH-1:0] sk_data_q [2];
  logic [DATA_WIDTH-1:0] sk_data_d [2];
  logic [5:0]            sk_idx_q [2];
  logic [5:0]            sk_idx_d [2];
  logic [1:0]            sk_cnt_q, sk_cnt_d;

  logic       wr_en, issue, release_rb, pop;
  logic [2:0] occ;

  assign out_valid = (sk_cnt_q != 2'd0);
  assign out_data  = sk_data_q[0];
  assign out_index = sk_idx_q[0];
  assign out_last  = out_valid && (sk_idx_q[0] == 6'd63);
  assign overflow  = ovf_q;
  assign pop       = out_valid && out_ready;

  // Reader walks the bank in zigzag order as RAM reads are issued; the index
  // travels with each word, and the bank is released once its last word is read.
  always_comb begin
    rs_d       = rs_q;
    rb_d       = rb_q;
    rc_d       = rc_q;
    occ        = {1'b0, sk_cnt_q} + {2'b00, rd_valid_q} - {2'b00, pop};
    issue      = (bank_q[rb_q] == B_FULL) && (occ < 3'd2);
    release_rb = issue && (rc_q == 6'd63);
    rd_valid_d = issue;
    rd_idx_d   = rc_q;
    case (rs_q)
      R_IDLE:  if (bank_q[rb_q] == B_FULL) rs_d = R_DRAIN;
      R_DRAIN: rs_d = R_DRAIN;
      default: rs_d = R_IDLE;
    endcase
    if (issue) begin
      rc_d = rc_q + 6'd1;
      if (rc_q == 6'd63) begin
        rb_d = ~rb_q;
        rs_d = (bank_q[~rb_q] == B_FULL) ? R_DRAIN : R_IDLE;
      end
    end
  end

  // A bank released on the same edge counts as free, so continuous input never stalls.
  always_comb begin
    ws_d  = ws_q;
    wb_d  = wb_q;
    wc_d  = wc_q;
    ovf_d = ovf_q;
    wr_en = 1'b0;
    case (ws_q)
      W_FILL: begin
        if (in_valid) begin
          wr_en = 1'b1;
          wc_d  = wc_q + 6'd1;
          if (wc_q == 6'd63) begin
            wb_d = ~wb_q;
            if ((bank_q[~wb_q] != B_EMPTY) && !(release_rb && (rb_q == ~wb_q)))
              ws_d = W_STALL;
          end
        end
      end
      W_STALL: begin
        if (in_valid) ovf_d = 1'b1;
        if (bank_q[wb_q] == B_EMPTY) ws_d = W_FILL;
      end
      default: ws_d = W_FILL;
    endcase
  end

  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    if (wr_en) bank_d[wb_q] = (wc_q == 6'd63) ? B_FULL : B_FILLING;
    if (release_rb) bank_d[rb_q] = B_EMPTY;
  end

  always_comb begin
    sk_data_d[0] = sk_data_q[0];
    sk_data_d[1] = sk_data_q[1];
    sk_idx_d[0]  = sk_idx_q[0];
    sk_idx_d[1]  = sk_idx_q[1];
    sk_cnt_d     = sk_cnt_q;
    if (pop) begin
      sk_data_d[0] = sk_data_q[1];
      sk_idx_d[0]  = sk_idx_q[1];
      sk_cnt_d     = sk_cnt_d - 2'd1;
    end
    if (rd_valid_q) begin
      if (sk_cnt_d == 2'd0) begin
        sk_data_d[0] = rd_data_q;
        sk_idx_d[0]  = rd_idx_q;
      end else begin
        sk_data_d[1] = rd_data_q;
        sk_idx_d[1]  = rd_idx_q;
      end
      sk_cnt_d = sk_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wb_q][wc_q] <= in_data;
    if (issue) rd_data_q <= mem_q[rb_q][ZZ[rc_q]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0]    <= B_EMPTY;
      bank_q[1]    <= B_EMPTY;
      ws_q         <= W_FILL;
      rs_q         <= R_IDLE;
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
      wc_q         <= 6'd0;
      rc_q         <= 6'd0;
      ovf_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_idx_q     <= 6'd0;
      sk_data_q[0] <= '0;
      sk_data_q[1] <= '0;
      sk_idx_q[0]  <= 6'd0;
      sk_idx_q[1]  <= 6'd0;
      sk_cnt_q     <= 2'd0;
    end else begin
      bank_q[0]    <= bank_d[0];
      bank_q[1]    <= bank_d[1];
      ws_q         <= ws_d;
      rs_q         <= rs_d;
      wb_q         <= wb_d;
      rb_q         <= rb_d;
      wc_q         <= wc_d;
      rc_q         <= rc_d;
      ovf_q        <= ovf_d;
      rd_valid_q   <= rd_valid_d;
      rd_idx_q     <= rd_idx_d;
      sk_data_q[0] <= sk_data_d[0];
      sk_data_q[1] <= sk_data_d[1];
      sk_idx_q[0]  <= sk_idx_d[0];
      sk_idx_q[1]  <= sk_idx_d[1];
      sk_cnt_q     <= sk_cnt_d;
    end
  end

endmodule

// File: tb/tb_dct_zigzag_buf.sv
// tb/tb_dct_zigzag_buf.sv - directed self-checking bench for dct_zigzag_buf
module tb_dct_zigzag_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [5:0] out_index;
  logic       overflow;

  dct_zigzag_buf #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_index(out_index), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Zigzag order built by walking anti-diagonals, independent of the RTL table.
  int zz [64];
  logic [7:0] exp_data [$];
  int         exp_idx [$];

  task automatic build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      for (int j = 0; j < 8; j++) begin
        int r = (s % 2 == 1) ? j : 7 - j;
        int c = s - r;
        if (c >= 0 && c < 8) begin
          zz[k] = 8 * r + c;
          k++;
        end
      end
    end
  endtask

  task automatic push_block(input int base);
    for (int k = 0; k < 64; k++) begin
      exp_data.push_back(8'(base + zz[k]));
      exp_idx.push_back(k);
    end
  endtask

  task automatic send_block(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      in_data  = 8'(base + i);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n = 0;
    while (exp_data.size() > 0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, exp_data.size(), 0);
  endtask

  int         hs_cnt = 0;
  int         gaps = 0;
  bit         gap_mon = 1'b0;
  bit         started = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] stall_data;
  logic [5:0] stall_idx;

  always @(negedge clk) begin
    logic [7:0] ed;
    int ei;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, stall_data);
        check("stall_index", out_index, stall_idx);
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_idx  = out_index;
      if (gap_mon && started && !out_valid && exp_data.size() > 0) gaps++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        started = 1'b1;
        if (exp_data.size() == 0) begin
          check("unexpected_word", out_valid, 0);
        end else begin
          ed = exp_data.pop_front();
          ei = exp_idx.pop_front();
          check("data", out_data, ed);
          check("index", out_index, ei);
          check("last", out_last, (ei == 63) ? 1 : 0);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    build_zz();
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single block, latency and zigzag order
    out_ready = 1'b1;
    hs_cnt = 0;
    push_block(0);
    send_block(0, 64);
    check("lat_t0_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_t1_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_t2_valid", out_valid, 1);
    check("lat_t2_data", out_data, 0);
    check("lat_t2_index", out_index, 0);
    wait_drain("single_drain", 200);
    check("single_hs", hs_cnt, 64);

    // four back-to-back blocks
    hs_cnt = 0;
    gaps = 0;
    started = 1'b0;
    gap_mon = 1'b1;
    for (int b = 0; b < 4; b++) push_block(b * 64 + 3);
    for (int b = 0; b < 4; b++) send_block(b * 64 + 3, 64);
    wait_drain("b2b_drain", 300);
    gap_mon = 1'b0;
    check("b2b_gaps", gaps, 0);
    check("b2b_hs", hs_cnt, 256);
    check("b2b_overflow", overflow, 0);

    // backpressure with alternating ready
    hs_cnt = 0;
    push_block(8'h55);
    send_block(8'h55, 64);
    for (int n = 0; n < 400 && exp_data.size() > 0; n++) begin
      out_ready = ~out_ready;
      @(posedge clk);
      #1;
    end
    check("bp_drain", exp_data.size(), 0);
    check("bp_hs", hs_cnt, 64);
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // overflow: three blocks with the sink stalled
    out_ready = 1'b0;
    hs_cnt = 0;
    push_block(100);
    push_block(150);
    send_block(100, 64);
    send_block(150, 64);
    check("ovf_before", overflow, 0);
    send_block(200, 1);
    check("ovf_rise", overflow, 1);
    send_block(201, 63);
    check("ovf_head_valid", out_valid, 1);
    check("ovf_head_data", out_data, 100);
    out_ready = 1'b1;
    wait_drain("ovf_drain", 400);
    check("ovf_hs", hs_cnt, 128);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("ovf_no_third", out_valid, 0);
    check("ovf_sticky", overflow, 1);

    // reset mid-operation
    hs_cnt = 0;
    push_block(10);
    send_block(10, 64);
    send_block(80, 30);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_half", (hs_cnt > 0 && hs_cnt < 64) ? 1 : 0, 1);
    exp_data.delete();
    exp_idx.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    check("post_rst_idle", out_valid, 0);
    check("post_rst_index", out_index, 0);
    hs_cnt = 0;
    push_block(7);
    send_block(7, 64);
    wait_drain("post_rst_drain", 200);
    check("post_rst_hs", hs_cnt, 64);
    check("post_rst_overflow", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
